// File: rtl/rpn_display.sv
// Result-display decoder: captures a signed 8-bit CPU result, converts its
// magnitude to BCD by iterative double-dabble and drives sign/hundreds/tens/ones digits.
module rpn_display #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic [7:0] Dout,
  input  logic       Dval,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic       Busy
);

  typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  state_t      state;
  logic [7:0]  shown;
  logic [2:0]  cnt;
  logic [19:0] sr;
  logic        neg;

  logic [19:0] adj;
  logic [19:0] nxt;
  logic [3:0]  hund, tens, ones;
  logic [7:0]  mag;
  logic        start;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Patterns are defined active-low; the parameter flips them for active-high boards.
  function automatic logic [6:0] drive(input logic [6:0] pat);
    drive = ACTIVE_LOW ? pat : ~pat;
  endfunction

  // NOTE: combinational next-state logic assigns every output first, so no latch is inferred.
  always_comb begin
    adj = sr;
    for (int k = 0; k < 3; k++) begin
      if (sr[8+4*k +: 4] >= 4'd5) adj[8+4*k +: 4] = sr[8+4*k +: 4] + 4'd3;
    end
    nxt   = adj << 1;
    hund  = nxt[19:16];
    tens  = nxt[15:12];
    ones  = nxt[11:8];
    mag   = Dout[7] ? (~Dout + 8'd1) : Dout;
    start = Dval && ((state == IDLE) || (Dout != shown));
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= IDLE;
      shown <= 8'd0;
      cnt   <= 3'd0;
      sr    <= 20'd0;
      neg   <= 1'b0;
      Busy  <= 1'b0;
      HEX0  <= drive(SEG_BLANK);
      HEX1  <= drive(SEG_BLANK);
      HEX2  <= drive(SEG_BLANK);
      HEX3  <= drive(SEG_BLANK);
    end else if (!Dval) begin
      state <= IDLE;
      Busy  <= 1'b0;
      HEX0  <= drive(SEG_BLANK);
      HEX1  <= drive(SEG_BLANK);
      HEX2  <= drive(SEG_BLANK);
      HEX3  <= drive(SEG_BLANK);
    end else begin
      case (state)
        IDLE, SHOW: begin
          if (start) begin
            shown <= Dout;
            neg   <= Dout[7];
            sr    <= {12'd0, mag};
            cnt   <= 3'd0;
            Busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          sr  <= nxt;
          cnt <= cnt + 3'd1;
          // Digits update only on the last shift, so the old value stays visible throughout.
          if (cnt == 3'd7) begin
            state <= SHOW;
            Busy  <= 1'b0;
            HEX3  <= drive(neg ? SEG_MINUS : SEG_BLANK);
            HEX2  <= drive((hund == 4'd0) ? SEG_BLANK : seg7(hund));
            HEX1  <= drive((hund == 4'd0 && tens == 4'd0) ? SEG_BLANK : seg7(tens));
            HEX0  <= drive(seg7(ones));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
